// File: rtl/topk_batch_scheduler_if.sv
// -----------------------------------------------------------------------------
// topk_batch_scheduler_if
// Bundles the three streams around the top-k batch scheduler:
//   upstream   : in_valid / in_ready / in_data / in_last
//   downstream : out_valid / out_ready / out_data / out_last
//   sorter     : srt_i_valid / srt_x (launch)  srt_y / srt_o_valid (result)
//   status     : busy, err_timeout
// slave modport is taken by the scheduler; master by whatever drives it.
// -----------------------------------------------------------------------------
interface topk_batch_scheduler_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int LOG_INPUT_NUM = 4
);
    localparam int N = 1 << LOG_INPUT_NUM;

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_last;
    logic                    srt_i_valid;
    logic [DATA_WIDTH*N-1:0] srt_x;
    logic [DATA_WIDTH*N-1:0] srt_y;
    logic                    srt_o_valid;
    logic                    busy;
    logic                    err_timeout;

    modport slave (
        input  in_valid, in_data, in_last, out_ready, srt_y, srt_o_valid,
        output in_ready, out_valid, out_data, out_last, srt_i_valid, srt_x,
               busy, err_timeout
    );

    modport master (
        output in_valid, in_data, in_last, out_ready, srt_y, srt_o_valid,
        input  in_ready, out_valid, out_data, out_last, srt_i_valid, srt_x,
               busy, err_timeout
    );
endinterface

// File: rtl/topk_batch_scheduler.sv
// -----------------------------------------------------------------------------
// topk_batch_scheduler
// Collects a serial element stream into batches of N = 2**LOG_INPUT_NUM slots
// (unused slots filled with PAD), launches an external descending sorter once
// per batch, waits for its result and streams out the top min(n, K) values.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - topk_batch_scheduler_if.slave (input/output streams, sorter link,
//          busy and sticky err_timeout status)
// -----------------------------------------------------------------------------
module topk_batch_scheduler #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    LOG_INPUT_NUM = 4,
    parameter int                    K             = 4,
    parameter logic [DATA_WIDTH-1:0] PAD           = 32'hFF800000,
    parameter int                    TIMEOUT       = 64
) (
    input logic                    clk,
    input logic                    rst,
    topk_batch_scheduler_if.slave  bus
);
    localparam int N  = 1 << LOG_INPUT_NUM;
    localparam int CW = LOG_INPUT_NUM + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t                        r_state, w_next;
    logic [N-1:0][DATA_WIDTH-1:0]  r_slots;
    logic [N-1:0][DATA_WIDTH-1:0]  r_res;
    logic [CW-1:0]                 r_count;
    logic [CW-1:0]                 r_n;
    logic [LOG_INPUT_NUM-1:0]      r_beat;
    logic [TW-1:0]                 r_wait;
    logic                          r_prev_ov;
    logic                          r_err;

    logic          w_in_ready, w_out_valid, w_srt_i_valid;
    logic          w_in_fire, w_close, w_capture, w_timeout, w_last_beat, w_out_fire;
    logic [CW-1:0] w_m;

    assign w_in_fire   = (r_state == S_LOAD) && bus.in_valid;
    assign w_close     = w_in_fire && (bus.in_last || (r_count == CW'(N-1)));
    // Only a fresh rising edge counts, so a level left over from the previous
    // batch cannot be mistaken for this batch's result.
    assign w_capture   = (r_state == S_WAIT) && bus.srt_o_valid && !r_prev_ov;
    assign w_timeout   = (r_state == S_WAIT) && !w_capture && (r_wait == TW'(TIMEOUT-1));
    assign w_m         = (r_n < CW'(K)) ? r_n : CW'(K);
    assign w_last_beat = (r_state == S_DRAIN) && ({1'b0, r_beat} == (w_m - 1'b1));
    assign w_out_fire  = (r_state == S_DRAIN) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_in_ready    = 1'b0;
        w_out_valid   = 1'b0;
        w_srt_i_valid = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (w_close) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_srt_i_valid = 1'b1;
                w_next        = S_WAIT;
            end
            S_WAIT: begin
                if (w_capture)      w_next = S_DRAIN;
                else if (w_timeout) w_next = S_LOAD;
            end
            S_DRAIN: begin
                w_out_valid = 1'b1;
                if (w_out_fire && w_last_beat) w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots   <= {N{PAD}};
            r_res     <= '0;
            r_count   <= '0;
            r_n       <= '0;
            r_beat    <= '0;
            r_wait    <= '0;
            r_prev_ov <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Sampled in every state so the edge detector is primed on WAIT entry.
            r_prev_ov <= bus.srt_o_valid;
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_slots[r_count[LOG_INPUT_NUM-1:0]] <= bus.in_data;
                        r_count <= r_count + 1'b1;
                        if (w_close) r_n <= r_count + 1'b1;
                    end
                end
                S_ISSUE: r_wait <= '0;
                S_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (w_capture) begin
                        r_res  <= bus.srt_y;
                        r_beat <= '0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_slots <= {N{PAD}};
                        r_count <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (w_last_beat) begin
                            r_slots <= {N{PAD}};
                            r_count <= '0;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = (r_state == S_DRAIN) ? r_res[r_beat] : '0;
    assign bus.out_last    = w_last_beat;
    assign bus.srt_i_valid = w_srt_i_valid;
    assign bus.srt_x       = r_slots;
    assign bus.busy        = !((r_state == S_LOAD) && (r_count == '0));
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_topk_batch_scheduler.sv
module tb_topk_batch_scheduler;
    localparam int DW = 32, LG = 4, N = 16, K = 4, TO = 64;
    localparam logic [31:0] PAD = 32'hFF800000;
    localparam int SM_NORMAL = 0, SM_STALE = 1, SM_TIMEOUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    topk_batch_scheduler_if #(.DATA_WIDTH(DW), .LOG_INPUT_NUM(LG)) ifc();

    topk_batch_scheduler #(.DATA_WIDTH(DW), .LOG_INPUT_NUM(LG), .K(K), .PAD(PAD),
                           .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    typedef struct { logic [31:0] d; logic l; } exp_t;
    exp_t sb[$];
    logic [31:0] cur[$];
    logic [N*DW-1:0] x_snap;
    logic [N*DW-1:0] all_pad;

    int total = 0, bad = 0, cyc = 0;
    int hs_cnt = 0, first_out = -1, last_hs = -1, ordy_mode = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Total order on non-NaN float bit patterns.
    function automatic logic [31:0] fkey(input logic [31:0] b);
        return b[31] ? ~b : (b | 32'h80000000);
    endfunction

    function automatic logic [31:0] int2f(input int i);
        int e = 0;
        while ((1 << (e + 1)) <= i) e++;
        return {1'b0, 8'(127 + e), 23'((i - (1 << e)) << (23 - e))};
    endfunction

    function automatic logic [31:0] rnd_float();
        return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    // External sorter model: full descending sort of all slots.
    function automatic logic [N*DW-1:0] sort_desc(input logic [N*DW-1:0] x);
        logic [31:0] a[N];
        logic [31:0] t;
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = x[DW*i +: DW];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (fkey(a[j]) < fkey(a[j+1])) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < N; i++) r[DW*i +: DW] = a[i];
        return r;
    endfunction

    // Scheduler reference: the m largest inputs, largest first, last flag on the final one.
    task automatic push_expected();
        logic [31:0] q[$];
        int m, bi;
        exp_t e;
        q = cur;
        m = (cur.size() < K) ? cur.size() : K;
        for (int j = 0; j < m; j++) begin
            bi = 0;
            for (int i = 1; i < q.size(); i++) if (fkey(q[i]) > fkey(q[bi])) bi = i;
            e.d = q[bi]; e.l = (j == m - 1);
            sb.push_back(e);
            q.delete(bi);
        end
    endtask

    // Output ready driver.
    initial begin
        forever begin
            @(posedge clk); #2;
            case (ordy_mode)
                0: ifc.out_ready = 1'b1;
                1: ifc.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: ifc.out_ready = 1'($urandom);
                default: ifc.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (ifc.out_valid) begin
                if (pv && !pr) begin
                    total++;
                    if (ifc.out_data !== pd || ifc.out_last !== pl) begin
                        bad++;
                        $display("FAIL hold: got %h/%b expected %h/%b", ifc.out_data, ifc.out_last, pd, pl);
                    end
                end
                if (first_out < 0) first_out = cyc;
                if (ifc.out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: got %h with nothing expected", ifc.out_data);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (ifc.out_data !== e.d || ifc.out_last !== e.l) begin
                            bad++;
                            $display("FAIL beat: got %h/last=%b expected %h/last=%b",
                                     ifc.out_data, ifc.out_last, e.d, e.l);
                        end
                    end
                    hs_cnt++;
                    last_hs = cyc;
                end
            end
            pv = ifc.out_valid; pr = ifc.out_ready; pd = ifc.out_data; pl = ifc.out_last;
        end
    end

    task automatic send_batch(input bit use_last);
        int n, g;
        logic [N*DW-1:0] ex;
        n = cur.size();
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            ifc.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ifc.in_valid = 1'b1;
            ifc.in_data  = cur[i];
            ifc.in_last  = use_last && (i == n - 1);
            g = 0;
            @(negedge clk);
            while (!ifc.in_ready && g < 50) begin @(negedge clk); g++; end
            if (!ifc.in_ready) chk("in_ready_stuck", 0, 1);
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_data  = $urandom;
        ex = all_pad;
        for (int i = 0; i < n; i++) ex[DW*i +: DW] = cur[i];
        @(negedge clk);
        chk("issue_pulse", ifc.srt_i_valid, 1);
        chk("issue_in_ready", ifc.in_ready, 0);
        chk("issue_busy", ifc.busy, 1);
        chk("srt_x_load", ifc.srt_x == ex, 1);
        x_snap = ifc.srt_x;
        @(negedge clk);
        chk("issue_once", ifc.srt_i_valid, 0);
    endtask

    task automatic sorter_resp(input int smode, output int w);
        logic seen;
        w = -1;
        if (smode == SM_NORMAL) begin
            @(posedge clk); #1;
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            ifc.srt_y = sort_desc(x_snap);
            ifc.srt_o_valid = 1'b1;
            w = cyc;
            @(posedge clk); #1;
            ifc.srt_o_valid = 1'b0;
        end else if (smode == SM_STALE) begin
            seen = 1'b0;
            repeat (6) begin @(negedge clk); if (ifc.out_valid) seen = 1'b1; end
            chk("stale_nocap", seen, 0);
            @(posedge clk); #1;
            ifc.srt_o_valid = 1'b0;
            @(posedge clk); #1;
            ifc.srt_y = sort_desc(x_snap);
            ifc.srt_o_valid = 1'b1;
            w = cyc;
        end
    endtask

    task automatic wait_done(input int m, input int w, input bit strict);
        int g = 0;
        @(negedge clk);
        while (!ifc.in_ready && g < 400) begin @(negedge clk); g++; end
        ifc.in_valid = 1'b0;
        chk("drain_done", ifc.in_ready, 1);
        chk("beat_count", hs_cnt, m);
        chk("ready_after_last", cyc, last_hs + 1);
        if (strict) begin
            chk("first_out_lat", first_out, w + 1);
            chk("last_beat_cyc", last_hs, w + m);
        end
        chk("sb_empty", sb.size(), 0);
        chk("pad_after", ifc.srt_x == all_pad, 1);
        chk("idle_busy", ifc.busy, 0);
    endtask

    task automatic run_batch(input bit use_last, input int smode, input int omode);
        int w, m, cnt;
        logic seen;
        ordy_mode = omode; hs_cnt = 0; first_out = -1; last_hs = -1;
        m = (cur.size() < K) ? cur.size() : K;
        if (smode == SM_STALE) begin
            ifc.srt_y = {N{32'h7F7FFFFF}};
            ifc.srt_o_valid = 1'b1;
        end
        if (smode != SM_TIMEOUT) push_expected();
        send_batch(use_last);
        ifc.in_valid = 1'b1;       // stalled input pressure while busy
        ifc.in_data  = 32'h7F000000;
        sorter_resp(smode, w);
        if (smode == SM_TIMEOUT) begin
            cnt = 0; seen = 1'b0;
            while (!ifc.err_timeout && cnt < 200) begin
                @(negedge clk); cnt++;
                if (ifc.out_valid) seen = 1'b1;
            end
            ifc.in_valid = 1'b0;
            chk("timeout_lat", cnt, TO);
            chk("timeout_in_ready", ifc.in_ready, 1);
            chk("timeout_noout", seen, 0);
            chk("timeout_pad", ifc.srt_x == all_pad, 1);
            chk("timeout_busy", ifc.busy, 0);
        end else begin
            wait_done(m, w, omode == 0);
        end
        @(posedge clk); #1;
        ifc.srt_o_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        cur.delete();
        for (int i = 0; i < n; i++) cur.push_back(rnd_float());
    endtask

    initial begin
        int w, g, n;
        logic [31:0] t;
        all_pad = {N{PAD}};
        ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0;
        ifc.out_ready = 1'b1; ifc.srt_y = '0; ifc.srt_o_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 1);
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_last", ifc.out_last, 0);
        chk("rst_out_data", ifc.out_data, 0);
        chk("rst_srt_i_valid", ifc.srt_i_valid, 0);
        chk("rst_err", ifc.err_timeout, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_srt_x", ifc.srt_x == all_pad, 1);

        // Full batch of 1.0..16.0 shuffled.
        cur.delete();
        for (int i = 1; i <= N; i++) cur.push_back(int2f(i));
        for (int i = N - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            t = cur[i]; cur[i] = cur[j]; cur[j] = t;
        end
        run_batch(1'b0, SM_NORMAL, 0);

        // Short batch: 5.0, -2.0, 7.0.
        cur.delete();
        cur.push_back(32'h40A00000); cur.push_back(32'hC0000000); cur.push_back(32'h40E00000);
        run_batch(1'b1, SM_NORMAL, 0);

        // Backpressure.
        fill_random(N);
        run_batch(1'b0, SM_NORMAL, 1);

        // Timeout, then a normal batch with the error staying set.
        fill_random(7);
        run_batch(1'b1, SM_TIMEOUT, 0);
        fill_random(9);
        run_batch(1'b1, SM_NORMAL, 0);
        chk("err_sticky", ifc.err_timeout, 1);

        // Stale srt_o_valid level.
        fill_random(N);
        run_batch(1'b0, SM_STALE, 0);

        // Reset after the 2nd output beat.
        fill_random(N);
        ordy_mode = 0; hs_cnt = 0; first_out = -1; last_hs = -1;
        push_expected();
        send_batch(1'b0);
        sorter_resp(SM_NORMAL, w);
        g = 0;
        while (hs_cnt < 2 && g < 100) begin @(negedge clk); #1; g++; end
        chk("mid_drain_beats", hs_cnt, 2);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", ifc.out_valid, 0);
        chk("mid_rst_in_ready", ifc.in_ready, 1);
        chk("mid_rst_srt_x", ifc.srt_x == all_pad, 1);
        chk("mid_rst_err", ifc.err_timeout, 0);
        fill_random(5);
        run_batch(1'b1, SM_NORMAL, 0);

        // Random batches.
        for (int b = 0; b < 10; b++) begin
            n = $urandom_range(1, N);
            fill_random(n);
            run_batch((n < N) ? 1'b1 : 1'($urandom), SM_NORMAL, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
